// File: rtl/exe_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : exe_wb_stage                                                |
// | Purpose  : Execute-to-writeback boundary. Two-entry skid buffer        |
// |            (OUT + SKID), Z/N flag register, operand forwarding and a   |
// |            saturating back-pressure counter.                           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module exe_wb_stage #(
  parameter int DW = 8,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_result,
  input  logic [RW-1:0] ex_dest,
  input  logic          ex_reg_we,
  input  logic          ex_flag_we,
  input  logic          flush,
  input  logic [RW-1:0] ra_idx,
  input  logic [RW-1:0] rb_idx,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_dest,
  output logic          wb_we,
  output logic          z_flag,
  output logic          n_flag,
  output logic [1:0]    fwd_sel_a,
  output logic [1:0]    fwd_sel_b,
  output logic [DW-1:0] fwd_data_a,
  output logic [DW-1:0] fwd_data_b,
  output logic [7:0]    stall_cnt
);

  localparam logic [7:0] c_STALL_MAX = 8'hFF;
  localparam logic [1:0] c_SEL_RF    = 2'b00;
  localparam logic [1:0] c_SEL_OUT   = 2'b01;
  localparam logic [1:0] c_SEL_SKID  = 2'b10;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic [RW-1:0] dest;
    logic          rwe;
    logic          fwe;
  } slot_t;

  slot_t      out_q, out_d;
  slot_t      skid_q, skid_d;
  slot_t      w_in;
  logic       z_q, z_d;
  logic       n_q, n_d;
  logic [7:0] stall_q, stall_d;
  logic       w_accept;
  logic       w_retire;

  // ex_ready comes straight from the SKID valid flop, so the upstream
  // handshake never sees a combinational path from wb_ready.
  assign w_accept = ex_valid & ~skid_q.valid;
  assign w_retire = out_q.valid & wb_ready;

  assign w_in = '{valid: 1'b1, data: ex_result, dest: ex_dest,
                  rwe: ex_reg_we, fwe: ex_flag_we};

  // Next-state for both slots, the flag register and the stall counter.
  always_comb begin
    out_d   = out_q;
    skid_d  = skid_q;
    z_d     = z_q;
    n_d     = n_q;
    stall_d = stall_q;

    if (!out_q.valid || wb_ready) begin
      // OUT is free this cycle: promote the older SKID entry first.
      if (skid_q.valid) begin
        out_d  = skid_q;
        skid_d = w_accept ? w_in : '0;
      end else begin
        out_d  = w_accept ? w_in : '0;
      end
    end else if (w_accept) begin
      skid_d = w_in;
    end

    // A branch squashes everything buffered, including a same-cycle accept.
    if (flush) begin
      out_d  = '0;
      skid_d = '0;
    end

    // The retiring entry still updates flags even in a flush cycle.
    if (w_retire && out_q.fwe) begin
      z_d = (out_q.data == '0);
      n_d = out_q.data[DW-1];
    end

    if (out_q.valid && !wb_ready && (stall_q != c_STALL_MAX)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      skid_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      stall_q <= 8'd0;
    end else begin
      out_q   <= out_d;
      skid_q  <= skid_d;
      z_q     <= z_d;
      n_q     <= n_d;
      stall_q <= stall_d;
    end
  end

  // Forwarding for source A: the younger SKID entry wins over OUT.
  always_comb begin
    fwd_sel_a  = c_SEL_RF;
    fwd_data_a = '0;
    if (skid_q.valid && skid_q.rwe && (skid_q.dest == ra_idx)) begin
      fwd_sel_a  = c_SEL_SKID;
      fwd_data_a = skid_q.data;
    end else if (out_q.valid && out_q.rwe && (out_q.dest == ra_idx)) begin
      fwd_sel_a  = c_SEL_OUT;
      fwd_data_a = out_q.data;
    end
  end

  // Forwarding for source B, same priority as source A.
  always_comb begin
    fwd_sel_b  = c_SEL_RF;
    fwd_data_b = '0;
    if (skid_q.valid && skid_q.rwe && (skid_q.dest == rb_idx)) begin
      fwd_sel_b  = c_SEL_SKID;
      fwd_data_b = skid_q.data;
    end else if (out_q.valid && out_q.rwe && (out_q.dest == rb_idx)) begin
      fwd_sel_b  = c_SEL_OUT;
      fwd_data_b = out_q.data;
    end
  end

  assign ex_ready  = ~skid_q.valid;
  assign wb_valid  = out_q.valid;
  assign wb_data   = out_q.data;
  assign wb_dest   = out_q.dest;
  assign wb_we     = out_q.valid & out_q.rwe;
  assign z_flag    = z_q;
  assign n_flag    = n_q;
  assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_exe_wb_stage                                             |
// | Purpose  : Directed, table-driven bench for exe_wb_stage.              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_exe_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid;
  logic       ex_ready;
  logic [7:0] ex_result;
  logic [1:0] ex_dest;
  logic       ex_reg_we;
  logic       ex_flag_we;
  logic       flush;
  logic [1:0] ra_idx;
  logic [1:0] rb_idx;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [1:0] wb_dest;
  logic       wb_we;
  logic       z_flag;
  logic       n_flag;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic [7:0] fwd_data_a;
  logic [7:0] fwd_data_b;
  logic [7:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_wb_stage #(.DW(8), .RW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_result  (ex_result),
    .ex_dest    (ex_dest),
    .ex_reg_we  (ex_reg_we),
    .ex_flag_we (ex_flag_we),
    .flush      (flush),
    .ra_idx     (ra_idx),
    .rb_idx     (rb_idx),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_dest    (wb_dest),
    .wb_we      (wb_we),
    .z_flag     (z_flag),
    .n_flag     (n_flag),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .stall_cnt  (stall_cnt)
  );

  // Inputs applied before a rising edge and outputs expected just after it.
  typedef struct packed {
    logic       ev;
    logic [7:0] res;
    logic [1:0] dest;
    logic       rwe;
    logic       fwe;
    logic       fl;
    logic       wbr;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_dest;
    logic       e_we;
    logic       e_ready;
    logic       e_z;
    logic       e_n;
    logic [1:0] e_sela;
    logic [7:0] e_da;
    logic [1:0] e_selb;
    logic [7:0] e_db;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input int idx, input string nm,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk(idx, "wb_valid",   {7'd0, wb_valid},   {7'd0, v.e_valid});
    chk(idx, "wb_data",    wb_data,            v.e_data);
    chk(idx, "wb_dest",    {6'd0, wb_dest},    {6'd0, v.e_dest});
    chk(idx, "wb_we",      {7'd0, wb_we},      {7'd0, v.e_we});
    chk(idx, "ex_ready",   {7'd0, ex_ready},   {7'd0, v.e_ready});
    chk(idx, "z_flag",     {7'd0, z_flag},     {7'd0, v.e_z});
    chk(idx, "n_flag",     {7'd0, n_flag},     {7'd0, v.e_n});
    chk(idx, "fwd_sel_a",  {6'd0, fwd_sel_a},  {6'd0, v.e_sela});
    chk(idx, "fwd_data_a", fwd_data_a,         v.e_da);
    chk(idx, "fwd_sel_b",  {6'd0, fwd_sel_b},  {6'd0, v.e_selb});
    chk(idx, "fwd_data_b", fwd_data_b,         v.e_db);
    chk(idx, "stall_cnt",  stall_cnt,          v.e_cnt);
  endtask

  task automatic drive(input vec_t v);
    ex_valid   = v.ev;
    ex_result  = v.res;
    ex_dest    = v.dest;
    ex_reg_we  = v.rwe;
    ex_flag_we = v.fwe;
    flush      = v.fl;
    wb_ready   = v.wbr;
    ra_idx     = v.ra;
    rb_idx     = v.rb;
  endtask

  initial begin
    vec_t idle;
    vec_t rst_exp;

    //        ev    res     dst   rwe   fwe   fl    wbr   ra    rb     | valid data   dst   we    rdy   z     n     sela  da     selb  db     cnt
    // Streaming 0x05, 0x00, 0x80 with flag updates
    vecs[0]  = '{1'b1,8'h05,2'd1,1'b1,1'b1,1'b0,1'b1,2'd0,2'd0, 1'b1,8'h05,2'd1,1'b1,1'b1,1'b0,1'b0,2'd0,8'h00,2'd0,8'h00,8'd0};
    vecs[1]  = '{1'b1,8'h00,2'd1,1'b1,1'b1,1'b0,1'b1,2'd0,2'd0, 1'b1,8'h00,2'd1,1'b1,1'b1,1'b0,1'b0,2'd0,8'h00,2'd0,8'h00,8'd0};
    vecs[2]  = '{1'b1,8'h80,2'd1,1'b1,1'b1,1'b0,1'b1,2'd0,2'd0, 1'b1,8'h80,2'd1,1'b1,1'b1,1'b1,1'b0,2'd0,8'h00,2'd0,8'h00,8'd0};
    vecs[3]  = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b1,2'd0,8'h00,2'd0,8'h00,8'd0};
    // Back-pressure: fill OUT and SKID, ex_ready drops, drain in order
    vecs[4]  = '{1'b1,8'h11,2'd1,1'b1,1'b1,1'b0,1'b0,2'd1,2'd0, 1'b1,8'h11,2'd1,1'b1,1'b1,1'b0,1'b1,2'd1,8'h11,2'd0,8'h00,8'd0};
    vecs[5]  = '{1'b1,8'h22,2'd1,1'b1,1'b1,1'b0,1'b0,2'd1,2'd0, 1'b1,8'h11,2'd1,1'b1,1'b0,1'b0,1'b1,2'd2,8'h22,2'd0,8'h00,8'd1};
    vecs[6]  = '{1'b1,8'h99,2'd2,1'b1,1'b1,1'b0,1'b0,2'd1,2'd0, 1'b1,8'h11,2'd1,1'b1,1'b0,1'b0,1'b1,2'd2,8'h22,2'd0,8'h00,8'd2};
    vecs[7]  = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0, 1'b1,8'h22,2'd1,1'b1,1'b1,1'b0,1'b0,2'd1,8'h22,2'd0,8'h00,8'd2};
    vecs[8]  = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0,2'd0,8'h00,2'd0,8'h00,8'd2};
    // Forwarding from both slots, then regfile
    vecs[9]  = '{1'b1,8'h33,2'd2,1'b1,1'b0,1'b0,1'b0,2'd2,2'd3, 1'b1,8'h33,2'd2,1'b1,1'b1,1'b0,1'b0,2'd1,8'h33,2'd0,8'h00,8'd2};
    vecs[10] = '{1'b1,8'h44,2'd3,1'b1,1'b0,1'b0,1'b0,2'd2,2'd3, 1'b1,8'h33,2'd2,1'b1,1'b0,1'b0,1'b0,2'd1,8'h33,2'd2,8'h44,8'd3};
    vecs[11] = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3, 1'b1,8'h33,2'd2,1'b1,1'b0,1'b0,1'b0,2'd0,8'h00,2'd2,8'h44,8'd4};
    // Flush with both slots full: OUT retires, input never appears
    vecs[12] = '{1'b1,8'h55,2'd1,1'b1,1'b1,1'b1,1'b1,2'd2,2'd3, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0,2'd0,8'h00,2'd0,8'h00,8'd4};
    vecs[13] = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0,2'd0,8'h00,2'd0,8'h00,8'd4};
    // Flush drops a real accept
    vecs[14] = '{1'b1,8'h66,2'd1,1'b1,1'b1,1'b1,1'b1,2'd1,2'd0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0,2'd0,8'h00,2'd0,8'h00,8'd4};
    // Retire in a flush cycle still updates flags
    vecs[15] = '{1'b1,8'h00,2'd0,1'b1,1'b1,1'b0,1'b1,2'd0,2'd0, 1'b1,8'h00,2'd0,1'b1,1'b1,1'b0,1'b0,2'd1,8'h00,2'd1,8'h00,8'd4};
    vecs[16] = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b1,1'b1,2'd0,2'd0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b1,1'b0,2'd0,8'h00,2'd0,8'h00,8'd4};
    // reg_we=0 entry: no forwarding, no write enable, flags hold
    vecs[17] = '{1'b1,8'h77,2'd1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0, 1'b1,8'h77,2'd1,1'b0,1'b1,1'b1,1'b0,2'd0,8'h00,2'd0,8'h00,8'd4};
    vecs[18] = '{1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b1,1'b0,2'd0,8'h00,2'd0,8'h00,8'd4};

    idle    = '0;
    rst_exp = '0;
    rst_exp.e_ready = 1'b1;

    // Reset
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk_all(i, vecs[i]);
    end

    // Stall counter saturation
    @(negedge clk);
    ex_valid = 1'b1; ex_result = 8'h80; ex_dest = 2'd1;
    ex_reg_we = 1'b1; ex_flag_we = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    ra_idx = 2'd0; rb_idx = 2'd0;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk(100, "stall_sat", stall_cnt, 8'hFF);
    chk(100, "stall_hold_valid", {7'd0, wb_valid}, 8'd1);
    chk(100, "stall_hold_data", wb_data, 8'h80);
    repeat (5) @(negedge clk);
    chk(101, "stall_no_wrap", stall_cnt, 8'hFF);

    // Reset mid-operation; z_flag was 1 beforehand
    rst_n = 1'b0;
    wb_ready = 1'b1;
    ex_valid = 1'b1;
    flush = 1'b1;
    ra_idx = 2'd1;
    @(posedge clk);
    #1;
    chk_all(102, rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;
    chk(103, "post_rst_ready", {7'd0, ex_ready}, 8'd1);
    chk(103, "post_rst_valid", {7'd0, wb_valid}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
